// File: rtl/frame_reader_pkg.sv
// frame_reader_pkg: shared widths and FSM encoding for the SDRAM frame read path.
package frame_reader_pkg;
    localparam int WORD_W       = 128;
    localparam int ADDR_W       = 25;
    localparam int FRAME_AW_DEF = 23;
    localparam int FRAME_IDX_W  = 2;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
endpackage

// File: rtl/frame_reader_if.sv
// frame_reader_if: control, SDRAM read-port and output-stream signals of frame_reader.
//   master: the reader (drives rd_req/rd_address, stream and status outputs)
//   slave : SDRAM controller plus consumer side
interface frame_reader_if;
    import frame_reader_pkg::*;
    logic                   start_frame;
    logic [FRAME_IDX_W-1:0] rd_frame;
    logic                   ram_busy;
    logic                   rd_req;
    logic [ADDR_W-1:0]      rd_address;
    logic [WORD_W-1:0]      ram_rd_data;
    logic                   ram_rd_valid;
    logic [WORD_W-1:0]      out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   frame_done;
    logic [15:0]            underrun_cnt;
    modport master (
        input  start_frame, rd_frame, ram_busy, ram_rd_data, ram_rd_valid, out_ready,
        output rd_req, rd_address, out_data, out_valid, busy, frame_done, underrun_cnt
    );
    modport slave (
        output start_frame, rd_frame, ram_busy, ram_rd_data, ram_rd_valid, out_ready,
        input  rd_req, rd_address, out_data, out_valid, busy, frame_done, underrun_cnt
    );
endinterface

// File: rtl/frame_reader_fifo.sv
// reader_fifo: synchronous show-ahead FIFO.
//   clk, rst_n (async, active-low); push/din write; pop/dout read (dout = head, 0 when empty);
//   count/empty/full status.
module reader_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_count;
    logic             w_push, w_pop;
    assign empty  = r_count == '0;
    assign full   = r_count == (AW+1)'(DEPTH);
    assign w_pop  = pop & ~empty;
    assign w_push = push & ~full;
    assign count  = r_count;
    // Forcing 0 when empty gives a defined head after reset without clearing the array.
    assign dout   = empty ? '0 : r_mem[r_rd];
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= din;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            if (w_push != w_pop) r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
        end
    end
endmodule

// File: rtl/frame_reader.sv
// frame_reader: fetches one frame from SDRAM as 128-bit words and streams it out.
//   clk_133M, rst_n_133M (async, active-low)
//   bus (frame_reader_if.master): start_frame/rd_frame control, rd_req/rd_address/ram_busy
//   request port, ram_rd_data/ram_rd_valid return port, out_data/out_valid/out_ready stream,
//   busy/frame_done status, underrun_cnt.
//   Optional macro FRAME_READER_UNDERRUN_EN enables the starvation counter.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int FRAME_WORDS = 38400,
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_AW    = FRAME_AW_DEF
) (
    input logic            clk_133M,
    input logic            rst_n_133M,
    frame_reader_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(FRAME_WORDS + 1);
    localparam logic [IW-1:0] LAST    = IW'(FRAME_WORDS);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(FIFO_DEPTH);

    state_t                 r_state;
    logic [FRAME_IDX_W-1:0] r_frame;
    logic [FRAME_AW-1:0]    r_offset;
    logic [IW-1:0]          r_issued;
    logic [CW-1:0]          r_outst;
    logic                   r_req, r_busy, r_done;
    logic [ADDR_W-1:0]      r_addr;
    logic [CW-1:0]          w_count;
    logic [CW:0]            w_level;
    logic [WORD_W-1:0]      w_head;
    logic                   w_empty, w_full, w_push, w_pop, w_issue;

    // Returns arriving with nothing outstanding (e.g. after a reset) are stale and dropped.
    assign w_push  = bus.ram_rd_valid & (r_outst != '0);
    assign w_pop   = ~w_empty & bus.out_ready;
    assign w_level = {1'b0, r_outst} + {1'b0, w_count};
    // Outstanding is counted at the decision edge, so the credit check already covers the
    // request that becomes visible on rd_req next cycle.
    assign w_issue = (r_state == FETCH) && !bus.ram_busy && (r_issued != LAST) && (w_level < DEPTH_L);

    reader_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_133M),
        .rst_n (rst_n_133M),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.ram_rd_data),
        .dout  (w_head),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            r_state  <= IDLE;
            r_frame  <= '0;
            r_offset <= '0;
            r_issued <= '0;
            r_outst  <= '0;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_req  <= w_issue;
            r_done <= 1'b0;
            if (w_issue) begin
                r_addr   <= ADDR_W'({r_frame, r_offset});
                r_offset <= r_offset + 1'b1;
                r_issued <= r_issued + 1'b1;
            end
            if (w_issue != w_push) r_outst <= w_issue ? r_outst + 1'b1 : r_outst - 1'b1;
            case (r_state)
                IDLE: if (bus.start_frame) begin
                    r_state  <= FETCH;
                    r_frame  <= bus.rd_frame;
                    r_offset <= '0;
                    r_issued <= '0;
                    r_busy   <= 1'b1;
                end
                FETCH: if (r_issued == LAST) r_state <= DRAIN;
                DRAIN: if (r_outst == '0 && w_empty) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk_133M) disable iff (!rst_n_133M) !(w_push && w_full));

    assign bus.rd_req     = r_req;
    assign bus.rd_address = r_addr;
    assign bus.out_data   = w_head;
    assign bus.out_valid  = ~w_empty;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;

`ifdef FRAME_READER_UNDERRUN_EN
    logic [15:0] r_underrun;
    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) r_underrun <= '0;
        else if (r_state == IDLE && bus.start_frame) r_underrun <= '0;
        else if ((r_state == FETCH || r_state == DRAIN) && bus.out_ready && w_empty && r_underrun != 16'hFFFF)
            r_underrun <= r_underrun + 1'b1;
    end
    assign bus.underrun_cnt = r_underrun;
`else
    assign bus.underrun_cnt = '0;
`endif
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: directed + randomized bench for frame_reader with an in-order SDRAM model.
module tb_frame_reader;
    localparam int FW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_reader_if bus();
    frame_reader #(.FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_133M   (clk),
        .rst_n_133M (rst_n),
        .bus        (bus)
    );

    int total = 0, bad = 0;
    int cyc = 0, gen = 0, lat = 3, ready_mode = 1, busy_from = 1, busy_to = 0;
    int n_req = 0, n_resp = 0, n_xfer = 0, exp_under = 0, t_last = -1;
    bit in_frame = 0, pend = 0, sf = 0, stray = 0, busy_rand = 0, prev_busy = 0;
    logic [1:0]  sf_frame = '0, exp_frame = '0;
    logic [95:0] salt;
    int          q_due[$], q_gen[$];
    logic [24:0] q_addr[$];

    function automatic logic [127:0] word(logic [24:0] a);
        return {salt[95:64] ^ {7'd0, a}, salt[63:32] + {7'd0, a}, ~{7'd0, a}, salt[31:0] ^ {a, 7'd0}};
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs of the new cycle against the model, then drive this cycle's inputs.
    task automatic tick();
        bit dv, ev, live, resp;
        @(posedge clk);
        #1;
        cyc++;
        if (pend) begin
            in_frame = 1;
            pend = 0;
        end
        dv = in_frame && t_last >= 0 && cyc == t_last + 2;
        ev = n_resp > n_xfer;
        check("frame_done", bus.frame_done, dv);
        check("busy", bus.busy, in_frame);
        check("out_valid", bus.out_valid, ev);
        if (ev) check("out_data", bus.out_data, word({exp_frame, 23'(n_xfer)}));
`ifdef FRAME_READER_UNDERRUN_EN
        check("underrun", bus.underrun_cnt, exp_under);
`else
        check("underrun", bus.underrun_cnt, 0);
`endif
        if (bus.rd_req) begin
            check("req_addr", bus.rd_address, {exp_frame, 23'(n_req)});
            check("req_window", in_frame && n_req < FW, 1);
            check("req_after_busy", prev_busy, 0);
            check("req_credit", (n_req + 1 - n_xfer) <= DEPTH, 1);
            q_due.push_back(cyc + lat);
            q_addr.push_back(bus.rd_address);
            q_gen.push_back(gen);
            n_req++;
        end
        bus.ram_busy    = busy_rand ? ($urandom_range(0, 3) == 0) : (cyc >= busy_from && cyc <= busy_to);
        bus.out_ready   = ready_mode == 2 ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
        bus.start_frame = sf;
        bus.rd_frame    = sf_frame;
        resp = 0;
        live = 0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            resp = 1;
            live = q_gen[0] == gen;
            bus.ram_rd_data = word(q_addr[0]);
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
            void'(q_gen.pop_front());
        end else if (stray) begin
            resp = 1;
            bus.ram_rd_data = {4{$urandom()}};
            stray = 0;
        end
        bus.ram_rd_valid = resp;
        if (ev && bus.out_ready) begin
            n_xfer++;
            if (n_xfer == FW) t_last = cyc;
        end
        if (live) n_resp++;
        if (in_frame && !dv && bus.out_ready && !ev && exp_under < 65535) exp_under++;
        if (sf && !in_frame) begin
            pend = 1;
            exp_frame = sf_frame;
            n_req = 0;
            n_resp = 0;
            n_xfer = 0;
            t_last = -1;
            exp_under = 0;
        end
        if (dv) in_frame = 0;
        sf = 0;
        prev_busy = bus.ram_busy;
    endtask

    task automatic wait_done(int budget);
        for (int n = 0; n < budget && (in_frame || pend); n++) tick();
        check("frame_timeout", in_frame || pend, 0);
    endtask

    task automatic run_frame(logic [1:0] f, int budget);
        sf = 1;
        sf_frame = f;
        tick();
        wait_done(budget);
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_rd_req"}, bus.rd_req, 0);
        check({tag, "_rd_address"}, bus.rd_address, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_frame_done"}, bus.frame_done, 0);
        check({tag, "_underrun"}, bus.underrun_cnt, 0);
    endtask

    initial begin
        salt = {$urandom(), $urandom(), $urandom()};
        bus.start_frame = 0;
        bus.rd_frame = 0;
        bus.ram_busy = 0;
        bus.ram_rd_data = '0;
        bus.ram_rd_valid = 0;
        bus.out_ready = 0;
        #3;
        check_reset_values("por");
        repeat (3) tick();
        rst_n = 1;
        tick();

        // Basic frame: frame 2, latency 3, always ready.
        lat = 3;
        ready_mode = 1;
        run_frame(2'd2, 200);
        check("basic_nreq", n_req, FW);
        check("basic_nxfer", n_xfer, FW);

        // Backpressure: consumer stalled, only DEPTH requests may go out.
        ready_mode = 0;
        sf = 1;
        sf_frame = 2'd1;
        tick();
        repeat (30) tick();
        check("bp_nreq", n_req, DEPTH);
        check("bp_nxfer", n_xfer, 0);
        ready_mode = 1;
        wait_done(200);
        check("bp_total", n_xfer, FW);

        // ram_busy window a few cycles after start.
        busy_from = cyc + 3;
        busy_to = cyc + 10;
        ready_mode = 2;
        run_frame(2'd3, 400);
        busy_from = 1;
        busy_to = 0;
        check("busy_nreq", n_req, FW);

        // start_frame during FETCH and in the DONE cycle are ignored.
        ready_mode = 1;
        sf = 1;
        sf_frame = 2'd3;
        tick();
        repeat (2) tick();
        sf = 1;
        sf_frame = 2'd0;
        tick();
        for (int n = 0; n < 200 && !(t_last >= 0 && cyc + 1 == t_last + 2); n++) tick();
        check("done_reached", t_last >= 0, 1);
        sf = 1;
        sf_frame = 2'd1;
        tick();
        repeat (5) tick();
        check("done_start_ignored", in_frame || pend, 0);
        stray = 1;
        repeat (4) tick();

        // Randomized frames.
        for (int k = 0; k < 4; k++) begin
            lat = $urandom_range(1, 6);
            ready_mode = 2;
            busy_rand = 1;
            run_frame(2'($urandom_range(0, 3)), 2000);
            check("rand_nxfer", n_xfer, FW);
        end
        busy_rand = 0;

        // Asynchronous reset after three requests; late returns must be ignored.
        lat = 6;
        ready_mode = 1;
        sf = 1;
        sf_frame = 2'd1;
        tick();
        for (int n = 0; n < 50 && n_req < 3; n++) tick();
        check("rst_nreq", n_req, 3);
        #2 rst_n = 0;
        #1;
        check_reset_values("midrst");
        gen++;
        in_frame = 0;
        pend = 0;
        n_req = 0;
        n_resp = 0;
        n_xfer = 0;
        t_last = -1;
        exp_under = 0;
        repeat (2) tick();
        rst_n = 1;
        for (int n = 0; n < 20 && q_due.size() > 0; n++) tick();
        check("rst_qdrain", q_due.size(), 0);
        repeat (2) tick();
        lat = 3;
        run_frame(2'd2, 200);
        check("rst_refetch", n_xfer, FW);

        // Starvation with long latency, then clear on the next accepted start.
        lat = 6;
        ready_mode = 1;
        run_frame(2'd0, 300);
`ifdef FRAME_READER_UNDERRUN_EN
        check("under_final", bus.underrun_cnt, exp_under);
        check("under_min", exp_under >= 8, 1);
`endif
        sf = 1;
        sf_frame = 2'd3;
        tick();
        tick();
        check("under_clear", bus.underrun_cnt, 0);
        wait_done(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
